// File: rtl/spi_regbank_rw.sv
// rtl/spi_regbank_rw.sv - SPI mode-0 peripheral with parametrised read/write register file
module spi_regbank_rw #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         copi,
    input  logic                         ncs,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [7:0]                   frame_err_cnt
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    // bit_cnt value while the last address bit is being sampled
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W);
    // bit_cnt value while the last data bit is being sampled
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(FRAME_W - 1);
    // bit_cnt value between address completion and the first data bit
    localparam logic [CNT_W-1:0] DATA_START = CNT_W'(ADDR_W + 1);
    localparam logic [ADDR_W:0]  NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_FULL,
        S_OVER,
        S_COMMIT
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
    logic                   sclk_d, ncs_d;
    logic [SYNC_STAGES:0]   settle;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall;
    logic                   armed, armed_now;

    logic [CNT_W-1:0]       bit_cnt;
    logic [FRAME_W-1:0]     rx_shift;
    logic [DATA_W-1:0]      tx_shift;
    logic                   rd_frame;
    logic                   was_full;
    logic [DATA_W-1:0]      regs [NUM_REGS];

    logic [ADDR_W-1:0]      addr_in;
    logic [DATA_W-1:0]      rd_val;
    logic                   c_rw;
    logic [ADDR_W-1:0]      c_addr;
    logic [DATA_W-1:0]      c_data;
    logic                   c_addr_ok;
    logic                   shift_en;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ncs_rise  = ncs_s & ~ncs_d;
    assign ncs_fall  = ~ncs_s & ncs_d;

    // A frame may only start once ncs has been seen high after the pipeline
    // flushed; this drops a frame that was already in flight at reset release.
    assign armed_now = armed | (settle[SYNC_STAGES] & ncs_d);

    // Address as it completes: the bits already shifted plus the bit on copi now
    assign addr_in   = {rx_shift[ADDR_W-2:0], copi_s};

    // Fields of a complete frame, held stable in rx_shift through COMMIT
    assign c_rw      = rx_shift[FRAME_W-1];
    assign c_addr    = rx_shift[FRAME_W-2 -: ADDR_W];
    assign c_data    = rx_shift[DATA_W-1:0];
    assign c_addr_ok = {1'b0, c_addr} < NUM_REGS_A;

    assign shift_en  = (state == S_ADDR || state == S_DATA) && sclk_rise && !ncs_rise;

    assign cipo_oe   = rd_frame && (state == S_DATA || state == S_FULL || state == S_OVER);
    assign cipo      = cipo_oe & tx_shift[DATA_W-1];

    // Synchronise the async SPI pins and keep one extra flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            sclk_d    <= 1'b0;
            ncs_d     <= 1'b1;
            settle    <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sclk_d    <= sclk_s;
            ncs_d     <= ncs_s;
            settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Read mux; unimplemented addresses read as zero
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_in == ADDR_W'(i)) begin
                rd_val = regs[i];
            end
        end
    end

    // Flatten the register file onto the configuration bus
    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs[i];
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; ncs rise beats a coincident sclk rise
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (ncs_fall && armed_now) state_next = S_ADDR;
            end
            S_ADDR: begin
                if (ncs_rise)                                state_next = S_COMMIT;
                else if (sclk_rise && bit_cnt == ADDR_LAST)  state_next = S_DATA;
            end
            S_DATA: begin
                if (ncs_rise)                                state_next = S_COMMIT;
                else if (sclk_rise && bit_cnt == DATA_LAST)  state_next = S_FULL;
            end
            S_FULL: begin
                if (ncs_rise)       state_next = S_COMMIT;
                else if (sclk_rise) state_next = S_OVER;
            end
            S_OVER: begin
                if (ncs_rise) state_next = S_COMMIT;
            end
            S_COMMIT: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Frame datapath: receive shifter, read-back shifter, commit and error count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed         <= 1'b0;
            bit_cnt       <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            rd_frame      <= 1'b0;
            was_full      <= 1'b0;
            wr_strobe     <= 1'b0;
            wr_addr       <= '0;
            frame_err_cnt <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_strobe <= 1'b0;
            armed     <= armed_now;

            if (state == S_IDLE && state_next == S_ADDR) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
                rd_frame <= 1'b0;
            end

            if (shift_en) begin
                rx_shift <= {rx_shift[FRAME_W-2:0], copi_s};
                bit_cnt  <= bit_cnt + 1'b1;
            end

            if (state == S_ADDR && state_next == S_DATA) begin
                rd_frame <= ~rx_shift[ADDR_W-1];
                if (!rx_shift[ADDR_W-1]) begin
                    tx_shift <= rd_val;
                end
            end

            // The fall right after address completion is the setup edge for the
            // MSB, so shifting starts only after the first data bit is sampled.
            if (state == S_DATA && sclk_fall && bit_cnt != DATA_START) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end

            if (state_next == S_COMMIT && state != S_COMMIT) begin
                was_full <= (state == S_FULL);
            end

            if (state == S_COMMIT) begin
                rd_frame <= 1'b0;
                if (was_full) begin
                    if (c_rw && c_addr_ok) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (c_addr == ADDR_W'(i)) begin
                                regs[i] <= c_data;
                            end
                        end
                        wr_strobe <= 1'b1;
                        wr_addr   <= c_addr;
                    end
                end else if (frame_err_cnt != 8'hFF) begin
                    frame_err_cnt <= frame_err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_regbank_rw.sv
// tb/tb_spi_regbank_rw.sv - scoreboard testbench for spi_regbank_rw
module tb_spi_regbank_rw;

    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 5;
    localparam int FLAT_W   = NUM_REGS * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sclk = 1'b0;
    logic              copi = 1'b0;
    logic              ncs = 1'b1;
    logic              cipo;
    logic              cipo_oe;
    logic [FLAT_W-1:0] regs_flat;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        frame_err_cnt;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] wexp_addr [$];
    logic [FLAT_W-1:0] wexp_regs [$];
    logic [DATA_W-1:0] rexp      [$];
    logic [DATA_W-1:0] model     [NUM_REGS];

    logic [DATA_W-1:0] rd_sh = '0;
    int                rd_n  = 0;

    spi_regbank_rw #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .NUM_REGS    (NUM_REGS),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sclk          (sclk),
        .copi          (copi),
        .ncs           (ncs),
        .cipo          (cipo),
        .cipo_oe       (cipo_oe),
        .regs_flat     (regs_flat),
        .wr_strobe     (wr_strobe),
        .wr_addr       (wr_addr),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FLAT_W-1:0] model_flat();
        logic [FLAT_W-1:0] f;
        f = '0;
        for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = model[i];
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = bits[i];
            tick(4);
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] bits, input int n, input int gap);
        ncs = 1'b0;
        tick(4);
        send_bits(bits, n);
        tick(4);
        ncs = 1'b1;
        tick(gap);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int gap);
        if (int'(a) < NUM_REGS) begin
            model[int'(a)] = d;
            wexp_addr.push_back(a);
            wexp_regs.push_back(model_flat());
        end
        frame({16'h0, 1'b1, a, d}, 16, gap);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input int gap);
        logic [7:0] hdr;
        hdr = {1'b0, a};
        rexp.push_back(exp);
        ncs = 1'b0;
        tick(4);
        send_bits({25'h0, hdr[7:1]}, 7);
        check("oe_addr_phase", cipo_oe, 1'b0);
        send_bits({31'h0, hdr[0]}, 1);
        send_bits(32'h0, 8);
        tick(4);
        ncs = 1'b1;
        tick(6);
        check("oe_after_frame", cipo_oe, 1'b0);
        tick(gap);
    endtask

    // Read-back monitor: assemble cipo on controller sampling edges
    always @(posedge sclk) begin
        if (cipo_oe) begin
            rd_sh = {rd_sh[DATA_W-2:0], cipo};
            rd_n++;
            if (rd_n == DATA_W) begin
                rd_n = 0;
                if (rexp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got %0h expected none", rd_sh);
                end else begin
                    check("read_data", rd_sh, rexp.pop_front());
                end
            end
        end
    end

    // Write monitor: every strobe must match the next queued commit
    always @(negedge clk) begin
        if (rst_n && wr_strobe) begin
            if (wexp_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr: got addr %0h expected none", wr_addr);
            end else begin
                check("wr_addr", wr_addr, wexp_addr.pop_front());
                check("wr_regs", regs_flat, wexp_regs.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

        tick(3);
        check("rst_regs", regs_flat, 40'h0);
        check("rst_strobe", wr_strobe, 1'b0);
        check("rst_wr_addr", wr_addr, 7'h0);
        check("rst_err", frame_err_cnt, 8'h0);
        check("rst_oe", cipo_oe, 1'b0);
        check("rst_cipo", cipo, 1'b0);
        rst_n = 1'b1;
        tick(10);

        // Single write
        do_write(7'h02, 8'hA5, 10);
        check("a5_flat", regs_flat, 40'h00_00A5_0000);
        check("a5_err", frame_err_cnt, 8'h0);

        // Write then read back
        do_write(7'h04, 8'h3C, 10);
        do_read(7'h04, 8'h3C, 10);
        check("rd_nomod", regs_flat, 40'h3C_00A5_0000);

        // Out-of-range read and write
        do_read(7'h10, 8'h00, 10);
        do_write(7'h10, 8'hFF, 10);
        check("oob_regs", regs_flat, 40'h3C_00A5_0000);
        check("oob_err", frame_err_cnt, 8'h0);
        check("oob_wr_addr", wr_addr, 7'h04);

        // Short and long frames
        frame({22'h0, 1'b1, 7'h01, 2'b01}, 10, 10);
        frame({15'h0, 1'b1, 7'h01, 8'h77, 1'b0}, 17, 10);
        check("err_two", frame_err_cnt, 8'd2);
        check("err_regs", regs_flat, 40'h3C_00A5_0000);
        for (int i = 0; i < 253; i++) frame(32'h0, 1, 6);
        check("err_reach", frame_err_cnt, 8'd255);
        for (int i = 0; i < 3; i++) frame(32'h0, 1, 6);
        check("err_sat", frame_err_cnt, 8'd255);

        // Reset in the middle of a write frame to addr 1
        ncs = 1'b0;
        tick(4);
        send_bits({23'h0, 1'b1, 7'h01, 1'b0}, 9);
        rst_n = 1'b0;
        #1;
        check("mid_rst_regs", regs_flat, 40'h0);
        check("mid_rst_err", frame_err_cnt, 8'h0);
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        tick(2);
        rst_n = 1'b1;
        send_bits({25'h0, 7'h5A}, 7);
        tick(4);
        ncs = 1'b1;
        tick(10);
        check("drop_err", frame_err_cnt, 8'h0);
        check("drop_regs", regs_flat, 40'h0);
        do_write(7'h01, 8'h5A, 10);
        check("after_rst_wr", regs_flat, 40'h00_0000_5A00);

        // Back-to-back writes with a 2-clk ncs-high gap
        do_write(7'h00, 8'h11, 2);
        do_write(7'h01, 8'h22, 10);
        check("b2b_regs", regs_flat, 40'h00_0000_2211);
        check("b2b_err", frame_err_cnt, 8'h0);

        tick(10);
        check("wr_queue_empty", wexp_addr.size(), 0);
        check("rd_queue_empty", rexp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_regbank_rw.md
Name: spi_regbank_rw

Overview:
- Parametrised SPI mode-0 peripheral with a generic register file; successor to the fixed 5×8 write-only register bank.
- Contains its own input synchronisers, edge detection, frame decoder and read-back shifter.
- Sits between the chip SPI pins and the PWM/output-enable logic; drives NUM_REGS×DATA_W configuration bits.

Parameters:
- ADDR_W, 7, address field width in frame.
- DATA_W, 8, register/data field width.
- NUM_REGS, 5, implemented registers at addresses 0..NUM_REGS-1 (NUM_REGS ≤ 2^ADDR_W).
- SYNC_STAGES, 2, flops per synchroniser on sclk/copi/ncs (≥2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- sclk  in  1  SPI clock, async to clk.
- copi  in  1  controller-out data, async.
- ncs  in  1  chip select, active-low, async.
- cipo  out  1  peripheral-out data.
- cipo_oe  out  1  output enable for cipo pad.
- regs_flat  out  NUM_REGS*DATA_W  register contents; reg i at bits [i*DATA_W +: DATA_W].
- wr_strobe  out  1  one-clk pulse on committed write.
- wr_addr  out  ADDR_W  address of last committed write.
- frame_err_cnt  out  8  saturating count of malformed frames.

Behaviour:
- Clock/reset: single clock clk; rst_n asynchronous assert, synchronous deassert at the top level. Reset clears all registers, synchronisers (ncs chain resets to 1), counters and outputs to 0, except cipo_oe=0 and FSM=IDLE.
- Inputs pass SYNC_STAGES flops, then one more for edge detect. Rise/fall of sclk and ncs are single-clk pulses. Required: f_sclk ≤ f_clk/8.
- Frame: FRAME_W = 1+ADDR_W+DATA_W bits, MSB first, sampled on sclk rise. Bit 0 is R/W (1=write, 0=read), then address, then data.
- FSM:
  - IDLE: on ncs fall → ADDR; clear bit counter and shift register.
  - ADDR: shift on each sclk rise. After 1+ADDR_W bits → DATA. If the frame is a read, load tx_shift with reg[addr] on the same clk, or 0 if addr ≥ NUM_REGS.
  - DATA: shift on sclk rise. After DATA_W bits → FULL.
  - FULL: any further sclk rise → OVER.
  - Any state on ncs rise → COMMIT.
  - COMMIT (1 clk): if prior state was FULL and R/W=1 and addr < NUM_REGS, write reg[addr] and pulse wr_strobe; set wr_addr. Write is visible on regs_flat the cycle after COMMIT.
    - If prior state was not FULL (short frame or OVER): no write, frame_err_cnt+1, saturating at 255.
    - Valid-length write to addr ≥ NUM_REGS: ignored, not an error.
    - Read frames never modify registers.
    - → IDLE.
- Read-back:
  - cipo_oe=1 while in DATA/FULL/OVER of a read frame, else 0.
  - cipo = tx_shift MSB. tx_shift shifts left on each sclk fall in DATA. cipo=0 when cipo_oe=0.
  - Sample for read is taken at address completion; a write in a concurrent frame is impossible (single port).
- Mid-frame reset: all state cleared. If synchronised ncs is low when reset releases, the FSM stays IDLE until an ncs rise→fall; the partial frame is dropped with no error count.
- sclk edges while ncs high are ignored. Simultaneous ncs rise and sclk rise in the same clk: ncs wins, edge not counted.

Test Plan:
- Write 0xA5 to addr 0x02 (frame 1_0000010_10100101, sclk=clk/8) → wr_strobe one pulse, wr_addr=2, regs_flat[23:16]=0xA5, others 0.
- Write addr 4 = 0x3C, then read addr 4 → cipo shifts 0,0,1,1,1,1,0,0 on the 8 data clocks; cipo_oe high only during data phase; registers unchanged.
- Read addr 0x10 (≥NUM_REGS) → cipo all 0; write to 0x10 → no wr_strobe, regs unchanged, frame_err_cnt=0.
- 10-bit frame and 17-bit frame → no writes, frame_err_cnt=2. 256 further short frames → saturates at 255.
- Assert rst_n low at bit 9 of a write to addr 1 → all regs 0 asynchronously. Release with ncs still low and continue clocking → no write, no error. Next full frame writes normally.
- Back-to-back writes to addr 0 (0x11) and addr 1 (0x22) with 2-clk ncs-high gap → both committed, two wr_strobe pulses.
